// File: rtl/noc_compute_node_if.sv
// noc_compute_node_if: flit/credit ports between a CONNECT router and a node.
// master = network side, slave = compute node side.
interface noc_compute_node_if #(
  parameter int DATA_W    = 32,
  parameter int DEST_BITS = 4,
  parameter int VC_BITS   = 1
);
  localparam int FLIT_W = 2 + DEST_BITS + VC_BITS + DATA_W;
  localparam int CR_W   = 1 + VC_BITS;

  logic [FLIT_W-1:0] flit_in;
  logic [CR_W-1:0]   credit_out;
  logic              credit_out_en;
  logic [FLIT_W-1:0] flit_out;
  logic              flit_out_en;
  logic [CR_W-1:0]   credit_in;

  modport master (
    output flit_in,
    output credit_in,
    input  credit_out,
    input  credit_out_en,
    input  flit_out,
    input  flit_out_en
  );

  modport slave (
    input  flit_in,
    input  credit_in,
    output credit_out,
    output credit_out_en,
    output flit_out,
    output flit_out_en
  );
endinterface

// File: rtl/noc_compute_node.sv
// noc_compute_node: CONNECT compute endpoint (input FIFO, operand pairer, ALU, credits).
// Macro NOC_NODE_SAT_EN: ADD/MUL saturate to all-ones instead of wrapping.
module noc_compute_node #(
  parameter int DATA_W      = 32,
  parameter int DEST_BITS   = 4,
  parameter int VC_BITS     = 1,
  parameter int OP          = 0,
  parameter int DEST_ID     = 0,
  parameter int OUT_VC      = 0,
  parameter int IN_DEPTH    = 4,
  parameter int OUT_CREDITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  noc_compute_node_if.slave   nif,
  output logic                overflow,
  output logic [7:0]          err_count,
  output logic [15:0]         result_count
);
  localparam int FLIT_W = 2 + DEST_BITS + VC_BITS + DATA_W;
  localparam int CR_W   = 1 + VC_BITS;
  localparam int ENT_W  = 1 + VC_BITS + DATA_W;
  localparam int AW     = $clog2(IN_DEPTH);
  localparam int CW     = $clog2(OUT_CREDITS + 1);

  localparam logic [1:0] S_GET_A     = 2'd0;
  localparam logic [1:0] S_GET_B     = 2'd1;
  localparam logic [1:0] S_EXEC      = 2'd2;
  localparam logic [1:0] S_SEND_WAIT = 2'd3;

  logic [ENT_W-1:0]  mem_q [IN_DEPTH];
  logic [AW-1:0]     wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [CW-1:0]     cr_q, cr_d;
  logic              ovf_q, ovf_d;
  logic [7:0]        err_q, err_d;
  logic [15:0]       rc_q, rc_d;
  logic [FLIT_W-1:0] fo_q, fo_d;
  logic              fo_en_q, fo_en_d;
  logic [CR_W-1:0]   co_q, co_d;
  logic              co_en_q, co_en_d;

  logic              in_vld, full, empty;
  logic              push, pop, send, err_inc, cr_ret;
  logic [ENT_W-1:0]  in_ent, hd;
  logic              hd_tail;
  logic [VC_BITS-1:0] hd_vc;
  logic [DATA_W-1:0] hd_data;
  logic [DATA_W-1:0] add_r, mul_r, res;
  logic              unused_in;

  // Only tail, vc and data are kept; dest is meaningless once delivered.
  assign in_vld    = nif.flit_in[FLIT_W-1];
  assign in_ent    = {nif.flit_in[FLIT_W-2],
                      nif.flit_in[VC_BITS+DATA_W-1:0]};
  assign unused_in = ^{nif.flit_in[FLIT_W-3 -: DEST_BITS],
                       nif.credit_in[VC_BITS-1:0]};
  assign cr_ret    = nif.credit_in[CR_W-1];

  assign full    = (cnt_q == (AW+1)'(IN_DEPTH));
  assign empty   = (cnt_q == '0);
  assign pop     = !empty &&
                   ((state_q == S_GET_A) || (state_q == S_GET_B));
  assign push    = in_vld && (!full || pop);

  assign hd      = mem_q[rp_q];
  assign hd_tail = hd[ENT_W-1];
  assign hd_vc   = hd[DATA_W +: VC_BITS];
  assign hd_data = hd[DATA_W-1:0];

`ifdef NOC_NODE_SAT_EN
  logic [DATA_W:0]     sum;
  logic [2*DATA_W-1:0] prod;
  assign sum   = {1'b0, a_q} + {1'b0, b_q};
  assign prod  = {{DATA_W{1'b0}}, a_q} * {{DATA_W{1'b0}}, b_q};
  assign add_r = sum[DATA_W] ? '1 : sum[DATA_W-1:0];
  assign mul_r = (|prod[2*DATA_W-1:DATA_W]) ? '1 : prod[DATA_W-1:0];
`else
  assign add_r = a_q + b_q;
  assign mul_r = a_q * b_q;
`endif

  // Operator select, fixed at elaboration by OP.
  always_comb begin
    res = '0;
    case (OP)
      0:       res = add_r;
      1:       res = mul_r;
      2:       res = a_q & b_q;
      3:       res = a_q | b_q;
      4:       res = a_q ^ b_q;
      default: res = add_r;
    endcase
  end

  // FIFO pointer and occupancy next-state.
  always_comb begin
    wp_d  = push ? wp_q + 1'b1 : wp_q;
    rp_d  = pop  ? rp_q + 1'b1 : rp_q;
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Operand pairing FSM with tail-based framing resync.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    send    = 1'b0;
    err_inc = 1'b0;
    unique case (state_q)
      S_GET_A: begin
        if (pop) begin
          if (!hd_tail) begin
            a_d     = hd_data;
            state_d = S_GET_B;
          end else begin
            err_inc = 1'b1;
          end
        end
      end
      S_GET_B: begin
        if (pop) begin
          if (hd_tail) begin
            b_d     = hd_data;
            state_d = S_EXEC;
          end else begin
            a_d     = hd_data;
            err_inc = 1'b1;
          end
        end
      end
      S_EXEC: begin
        if (cr_q != '0) begin
          send    = 1'b1;
          state_d = S_GET_A;
        end else begin
          state_d = S_SEND_WAIT;
        end
      end
      S_SEND_WAIT: begin
        if (cr_q != '0) begin
          send    = 1'b1;
          state_d = S_GET_A;
        end
      end
      default: state_d = S_GET_A;
    endcase
  end

  // Send credits, status counters and registered output flits.
  always_comb begin
    cr_d = cr_q;
    unique case ({cr_ret, send})
      2'b10:   cr_d = (cr_q == CW'(OUT_CREDITS)) ? cr_q : cr_q + 1'b1;
      2'b01:   cr_d = cr_q - 1'b1;
      default: cr_d = cr_q;
    endcase
    ovf_d   = ovf_q | (in_vld & full & !pop);
    err_d   = (err_inc && (err_q != 8'hFF)) ? err_q + 1'b1 : err_q;
    rc_d    = send ? rc_q + 1'b1 : rc_q;
    fo_en_d = send;
    fo_d    = send ? {1'b1, 1'b1, DEST_BITS'(DEST_ID),
                      VC_BITS'(OUT_VC), res} : '0;
    co_en_d = pop;
    co_d    = pop ? {1'b1, hd_vc} : '0;
  end

  // FIFO storage; contents are discarded on reset via the pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= in_ent;
  end

  // FIFO pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  // FSM, operand latches and credit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_GET_A;
      a_q     <= '0;
      b_q     <= '0;
      cr_q    <= CW'(OUT_CREDITS);
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cr_q    <= cr_d;
    end
  end

  // Registered outputs and status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q   <= 1'b0;
      err_q   <= '0;
      rc_q    <= '0;
      fo_q    <= '0;
      fo_en_q <= 1'b0;
      co_q    <= '0;
      co_en_q <= 1'b0;
    end else begin
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      rc_q    <= rc_d;
      fo_q    <= fo_d;
      fo_en_q <= fo_en_d;
      co_q    <= co_d;
      co_en_q <= co_en_d;
    end
  end

  assign nif.flit_out      = fo_q;
  assign nif.flit_out_en   = fo_en_q;
  assign nif.credit_out    = co_q;
  assign nif.credit_out_en = co_en_q;
  assign overflow          = ovf_q;
  assign err_count         = err_q;
  assign result_count      = rc_q;
endmodule

// File: tb/tb_noc_compute_node.sv
// tb_noc_compute_node: directed bench, three nodes (ADD/MUL/XOR) on shared stimulus.
// DATA_W=8, DEST_ID=3, OUT_VC=1, IN_DEPTH=4, OUT_CREDITS=2.
module tb_noc_compute_node;
  localparam int FW = 15;

`ifdef NOC_NODE_SAT_EN
  localparam logic [7:0] M1 = 8'hFF;
  localparam logic [7:0] A2 = 8'hFF;
  localparam logic [7:0] M2 = 8'hFF;
`else
  localparam logic [7:0] M1 = 8'h90;
  localparam logic [7:0] A2 = 8'h2C;
  localparam logic [7:0] M2 = 8'h20;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [FW-1:0] flit_in;
  logic [1:0] credit_in;
  logic ovf_a, ovf_m, ovf_x;
  logic [7:0] err_a, err_m, err_x;
  logic [15:0] rc_a, rc_m, rc_x;

  always #5 clk = ~clk;

  noc_compute_node_if #(.DATA_W(8), .DEST_BITS(4), .VC_BITS(1)) if_add ();
  noc_compute_node_if #(.DATA_W(8), .DEST_BITS(4), .VC_BITS(1)) if_mul ();
  noc_compute_node_if #(.DATA_W(8), .DEST_BITS(4), .VC_BITS(1)) if_xor ();

  assign if_add.flit_in = flit_in;
  assign if_mul.flit_in = flit_in;
  assign if_xor.flit_in = flit_in;
  assign if_add.credit_in = credit_in;
  assign if_mul.credit_in = credit_in;
  assign if_xor.credit_in = credit_in;

  noc_compute_node #(.DATA_W(8), .DEST_BITS(4), .VC_BITS(1), .OP(0),
    .DEST_ID(3), .OUT_VC(1), .IN_DEPTH(4), .OUT_CREDITS(2)) u_add (
    .clk(clk), .rst(rst), .nif(if_add.slave),
    .overflow(ovf_a), .err_count(err_a), .result_count(rc_a));

  noc_compute_node #(.DATA_W(8), .DEST_BITS(4), .VC_BITS(1), .OP(1),
    .DEST_ID(3), .OUT_VC(1), .IN_DEPTH(4), .OUT_CREDITS(2)) u_mul (
    .clk(clk), .rst(rst), .nif(if_mul.slave),
    .overflow(ovf_m), .err_count(err_m), .result_count(rc_m));

  noc_compute_node #(.DATA_W(8), .DEST_BITS(4), .VC_BITS(1), .OP(4),
    .DEST_ID(3), .OUT_VC(1), .IN_DEPTH(4), .OUT_CREDITS(2)) u_xor (
    .clk(clk), .rst(rst), .nif(if_xor.slave),
    .overflow(ovf_x), .err_count(err_x), .result_count(rc_x));

  logic [FW-1:0] q_add[$];
  logic [FW-1:0] q_mul[$];
  logic [FW-1:0] q_xor[$];
  int crp = 0;

  always @(negedge clk) begin
    if (if_add.flit_out_en) q_add.push_back(if_add.flit_out);
    if (if_mul.flit_out_en) q_mul.push_back(if_mul.flit_out);
    if (if_xor.flit_out_en) q_xor.push_back(if_xor.flit_out);
    if (if_add.credit_out_en) crp++;
  end

  int n_chk = 0;
  int n_fail = 0;
  int c0;

  function automatic logic [FW-1:0] rf(logic [7:0] d);
    return {1'b1, 1'b1, 4'd3, 1'b1, d};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_res(string tag, logic [7:0] ea, logic [7:0] em,
                         logic [7:0] ex);
    logic [FW-1:0] v;
    v = '0;
    if (q_add.size() > 0) v = q_add.pop_front();
    chk({tag, "_add"}, 32'(v), 32'(rf(ea)));
    v = '0;
    if (q_mul.size() > 0) v = q_mul.pop_front();
    chk({tag, "_mul"}, 32'(v), 32'(rf(em)));
    v = '0;
    if (q_xor.size() > 0) v = q_xor.pop_front();
    chk({tag, "_xor"}, 32'(v), 32'(rf(ex)));
  endtask

  task automatic step(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic put(logic t, logic vc, logic [7:0] d);
    flit_in = {1'b1, t, 4'd5, vc, d};
    step();
    flit_in = '0;
  endtask

  task automatic cred();
    credit_in = 2'b10;
    step();
    credit_in = 2'b00;
  endtask

  initial begin
    rst = 1'b1;
    flit_in = '0;
    credit_in = '0;
    step(2);
    chk("rst_fo_en", 32'(if_add.flit_out_en), 0);
    chk("rst_fo", 32'(if_add.flit_out), 0);
    chk("rst_co_en", 32'(if_add.credit_out_en), 0);
    chk("rst_co", 32'(if_add.credit_out), 0);
    chk("rst_ovf", 32'(ovf_a), 0);
    chk("rst_err", 32'(err_a), 0);
    chk("rst_rc", 32'(rc_a), 0);
    rst = 1'b0;
    step();

    // Basic pair 3, 5
    c0 = crp;
    put(1'b0, 1'b0, 8'd3);
    put(1'b1, 1'b1, 8'd5);
    chk("t1_co_en_a", 32'(if_add.credit_out_en), 1);
    chk("t1_co_a", 32'(if_add.credit_out), 32'h2);
    step();
    chk("t1_co_en_b", 32'(if_add.credit_out_en), 1);
    chk("t1_co_b", 32'(if_add.credit_out), 32'h3);
    chk("t1_fo_en_early", 32'(if_add.flit_out_en), 0);
    step();
    chk("t1_fo_en", 32'(if_add.flit_out_en), 1);
    chk("t1_fo", 32'(if_add.flit_out), 32'(rf(8'd8)));
    chk("t1_co_en_off", 32'(if_add.credit_out_en), 0);
    step();
    chk("t1_fo_en_off", 32'(if_add.flit_out_en), 0);
    chk("t1_fo_off", 32'(if_add.flit_out), 0);
    chk("t1_rc", 32'(rc_a), 1);
    chk("t1_crp", 32'(crp - c0), 2);
    chk_res("t1", 8'd8, 8'd15, 8'd6);

    // Restore credits; the second return is beyond the maximum.
    cred();
    cred();

    // Three pairs with two credits: third waits.
    put(1'b0, 1'b0, 8'd20);
    put(1'b1, 1'b0, 8'd20);
    put(1'b0, 1'b1, 8'd200);
    put(1'b1, 1'b1, 8'd100);
    put(1'b0, 1'b0, 8'd7);
    put(1'b1, 1'b0, 8'd9);
    step(6);
    chk("t3_rc_stall", 32'(rc_a), 3);
    chk("t3_fo_en_stall", 32'(if_add.flit_out_en), 0);
    chk_res("t3_p1", 8'h28, M1, 8'h00);
    chk_res("t3_p2", A2, M2, 8'hAC);

    // Fill FIFO while stalled; the fifth flit is dropped.
    c0 = crp;
    put(1'b0, 1'b0, 8'd1);
    put(1'b1, 1'b1, 8'd2);
    put(1'b0, 1'b0, 8'd4);
    put(1'b1, 1'b0, 8'd6);
    chk("t5_ovf_pre", 32'(ovf_a), 0);
    put(1'b1, 1'b1, 8'd15);
    chk("t5_ovf", 32'(ovf_a), 1);
    step(2);
    chk("t5_no_pop", 32'(crp - c0), 0);
    chk("t5_fo_en_wait", 32'(if_add.flit_out_en), 0);
    cred();
    chk("t3_fo_en_cred", 32'(if_add.flit_out_en), 0);
    step();
    chk("t3_fo_en_rel", 32'(if_add.flit_out_en), 1);
    chk("t3_fo_rel", 32'(if_add.flit_out), 32'(rf(8'd16)));
    cred();
    cred();
    step(8);
    chk("t5_rc", 32'(rc_a), 6);
    chk("t5_err", 32'(err_a), 0);
    chk("t5_ovf_sticky", 32'(ovf_a), 1);
    chk("t5_crp", 32'(crp - c0), 4);
    chk_res("t3_p3", 8'h10, 8'h3F, 8'h0E);
    chk_res("t5_p1", 8'h03, 8'h02, 8'h03);
    chk_res("t5_p2", 8'h0A, 8'h18, 8'h02);

    // Framing errors: lone tail, then resync.
    cred();
    c0 = crp;
    put(1'b1, 1'b0, 8'd7);
    put(1'b0, 1'b0, 8'd1);
    put(1'b0, 1'b1, 8'd2);
    put(1'b1, 1'b1, 8'd4);
    step(6);
    chk("t4_err", 32'(err_a), 2);
    chk("t4_err_xor", 32'(err_x), 2);
    chk("t4_crp", 32'(crp - c0), 4);
    chk("t4_rc", 32'(rc_a), 7);
    chk_res("t4", 8'h06, 8'h08, 8'h06);

    // Reset while A is latched in GET_B.
    put(1'b0, 1'b0, 8'd9);
    step();
    rst = 1'b1;
    #1;
    chk("t6_fo_en", 32'(if_add.flit_out_en), 0);
    chk("t6_fo", 32'(if_add.flit_out), 0);
    chk("t6_co_en", 32'(if_add.credit_out_en), 0);
    chk("t6_co", 32'(if_add.credit_out), 0);
    chk("t6_ovf", 32'(ovf_a), 0);
    chk("t6_err", 32'(err_a), 0);
    chk("t6_rc", 32'(rc_a), 0);
    step();
    rst = 1'b0;
    step();
    put(1'b0, 1'b0, 8'd10);
    put(1'b1, 1'b0, 8'd11);
    put(1'b0, 1'b0, 8'd2);
    put(1'b1, 1'b1, 8'd3);
    step(8);
    chk("t6_rc_after", 32'(rc_a), 2);
    chk_res("t6_p1", 8'h15, 8'h6E, 8'h01);
    chk_res("t6_p2", 8'h05, 8'h06, 8'h01);
    chk("t6_q_empty", 32'(q_add.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
